// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared pipeline types for the hazard scoreboard
package hazard_scoreboard_pkg;

  localparam int NREGS_DEFAULT    = 32;
  localparam int MAX_LONG_DEFAULT = 4;

  typedef enum logic [2:0] {
    FWD_RF   = 3'd0,
    FWD_EX   = 3'd1,
    FWD_MEM  = 3'd2,
    FWD_WB   = 3'd3,
    FWD_LONG = 3'd4
  } fwd_sel_t;

  // Producer view of an in-flight instruction, as seen by the match logic.
  typedef struct packed {
    logic valid;
    logic en_rd;
  } decoded_inst_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - pipeline-side bundle for the hazard scoreboard
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int MAX_LONG = MAX_LONG_DEFAULT,
  parameter int CNT_W    = $clog2(MAX_LONG + 1)
);
  logic             id_valid, id_en_rs1, id_en_rs2, id_en_rd, id_is_ecall;
  logic [REG_W-1:0] id_rs1, id_rs2, id_rd;
  logic             ex_valid, ex_en_rd, ex_is_load, ex_is_long;
  logic [REG_W-1:0] ex_rd;
  logic             mem_valid, mem_en_rd, mem_is_load, mem_is_store;
  logic [REG_W-1:0] mem_rd;
  logic             wb_valid, wb_en_rd, wb_is_ecall;
  logic [REG_W-1:0] wb_rd;
  logic             dcache_enable, dcache_valid, write_done;
  logic             ecall_stall;
  logic             long_done;
  logic [REG_W-1:0] long_done_rd;

  logic             id_stall, ex_stall, mem_stall, wb_stall;
  logic             flush_before_wb, long_kill;
  fwd_sel_t         fwd_rs1_sel, fwd_rs2_sel;
  logic [CNT_W-1:0] long_count;

  modport master (
    output id_valid, id_en_rs1, id_en_rs2, id_en_rd, id_is_ecall, id_rs1, id_rs2, id_rd,
    output ex_valid, ex_en_rd, ex_is_load, ex_is_long, ex_rd,
    output mem_valid, mem_en_rd, mem_is_load, mem_is_store, mem_rd,
    output wb_valid, wb_en_rd, wb_is_ecall, wb_rd,
    output dcache_enable, dcache_valid, write_done, ecall_stall, long_done, long_done_rd,
    input  id_stall, ex_stall, mem_stall, wb_stall, flush_before_wb, long_kill,
    input  fwd_rs1_sel, fwd_rs2_sel, long_count
  );

  modport slave (
    input  id_valid, id_en_rs1, id_en_rs2, id_en_rd, id_is_ecall, id_rs1, id_rs2, id_rd,
    input  ex_valid, ex_en_rd, ex_is_load, ex_is_long, ex_rd,
    input  mem_valid, mem_en_rd, mem_is_load, mem_is_store, mem_rd,
    input  wb_valid, wb_en_rd, wb_is_ecall, wb_rd,
    input  dcache_enable, dcache_valid, write_done, ecall_stall, long_done, long_done_rd,
    output id_stall, ex_stall, mem_stall, wb_stall, flush_before_wb, long_kill,
    output fwd_rs1_sel, fwd_rs2_sel, long_count
  );

endinterface

// File: rtl/hazard_scoreboard_long_scoreboard.sv
// rtl/hazard_scoreboard_long_scoreboard.sv - busy vector and outstanding counter for the long unit
module long_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREGS    = NREGS_DEFAULT,
  parameter int REG_W    = $clog2(NREGS),
  parameter int MAX_LONG = MAX_LONG_DEFAULT,
  parameter int CNT_W    = $clog2(MAX_LONG + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             accept,
  input  logic             accept_en_rd,
  input  logic [REG_W-1:0] accept_rd,
  input  logic             done,
  input  logic [REG_W-1:0] done_rd,
  output logic [NREGS-1:0] busy,
  output logic [CNT_W-1:0] count
);
  logic [NREGS-1:0] set_mask, clr_mask;
  logic             dec;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (accept && accept_en_rd && accept_rd != '0) set_mask[accept_rd] = 1'b1;
    if (done) clr_mask[done_rd] = 1'b1;
  end

  // A stray completion at zero is held, not wrapped.
  assign dec = done && (count != '0);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      busy  <= '0;
      count <= '0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
      case ({accept, dec})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  underflow_check: assert property (@(posedge clk) disable iff (reset || flush)
    done |-> (count != '0));

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - stall cascade, operand forwarding and ecall flush with long-op scoreboard
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREGS    = NREGS_DEFAULT,
  parameter int REG_W    = $clog2(NREGS),
  parameter int MAX_LONG = MAX_LONG_DEFAULT
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave hz
);
  localparam int CNT_W = $clog2(MAX_LONG + 1);

  logic [NREGS-1:0] busy;
  logic [CNT_W-1:0] long_count;
  decoded_inst_t    ex_p, mem_p, wb_p;

  logic ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2, ld_m1, ld_m2;
  logic busy1, busy2, ex_fwd_ok, load_use, ex_long_use, waw, ecall_drain;
  logic ex_long_block, accept, flush;

  function automatic logic src_match(logic en, decoded_inst_t p,
                                     logic [REG_W-1:0] src, logic [REG_W-1:0] rd);
    return en && p.valid && p.en_rd && (src == rd) && (src != '0);
  endfunction

  function automatic fwd_sel_t pick(logic ex_ok, logic mem_m, logic wb_m, logic ld_m);
    if (ex_ok) return FWD_EX;
    if (mem_m) return FWD_MEM;
    if (wb_m)  return FWD_WB;
    if (ld_m)  return FWD_LONG;
    return FWD_RF;
  endfunction

  assign ex_p  = '{valid: hz.ex_valid,  en_rd: hz.ex_en_rd};
  assign mem_p = '{valid: hz.mem_valid, en_rd: hz.mem_en_rd};
  assign wb_p  = '{valid: hz.wb_valid,  en_rd: hz.wb_en_rd};

  assign ex_m1  = src_match(hz.id_en_rs1, ex_p,  hz.id_rs1, hz.ex_rd);
  assign ex_m2  = src_match(hz.id_en_rs2, ex_p,  hz.id_rs2, hz.ex_rd);
  assign mem_m1 = src_match(hz.id_en_rs1, mem_p, hz.id_rs1, hz.mem_rd);
  assign mem_m2 = src_match(hz.id_en_rs2, mem_p, hz.id_rs2, hz.mem_rd);
  assign wb_m1  = src_match(hz.id_en_rs1, wb_p,  hz.id_rs1, hz.wb_rd);
  assign wb_m2  = src_match(hz.id_en_rs2, wb_p,  hz.id_rs2, hz.wb_rd);
  assign ld_m1  = hz.long_done && hz.id_en_rs1 && (hz.id_rs1 == hz.long_done_rd) && (hz.id_rs1 != '0);
  assign ld_m2  = hz.long_done && hz.id_en_rs2 && (hz.id_rs2 == hz.long_done_rd) && (hz.id_rs2 != '0);

  // A pending long write is bypassed only in the exact cycle it lands.
  assign busy1 = hz.id_en_rs1 && (hz.id_rs1 != '0) && busy[hz.id_rs1] && !ld_m1;
  assign busy2 = hz.id_en_rs2 && (hz.id_rs2 != '0) && busy[hz.id_rs2] && !ld_m2;

  assign ex_fwd_ok   = !hz.ex_is_load && !hz.ex_is_long;
  assign load_use    = hz.ex_is_load && (ex_m1 || ex_m2);
  assign ex_long_use = hz.ex_is_long && (ex_m1 || ex_m2);
  assign waw         = hz.id_en_rd && busy[hz.id_rd];
  assign ecall_drain = hz.id_is_ecall && (long_count != '0);

  assign ex_long_block = hz.ex_valid && hz.ex_is_long &&
                         ((long_count == CNT_W'(MAX_LONG)) || (hz.ex_en_rd && busy[hz.ex_rd]));

  assign hz.wb_stall  = hz.ecall_stall;
  assign hz.mem_stall = (hz.dcache_enable && ((hz.mem_is_load && !hz.dcache_valid) ||
                                              (hz.mem_is_store && !hz.write_done))) || hz.wb_stall;
  assign hz.ex_stall  = hz.mem_stall || ex_long_block;
  assign hz.id_stall  = hz.id_valid && (hz.ex_stall || load_use || ex_long_use ||
                                        busy1 || busy2 || waw || ecall_drain);

  assign hz.fwd_rs1_sel = pick(ex_m1 && ex_fwd_ok, mem_m1, wb_m1, ld_m1);
  assign hz.fwd_rs2_sel = pick(ex_m2 && ex_fwd_ok, mem_m2, wb_m2, ld_m2);

  assign flush              = hz.wb_valid && hz.wb_is_ecall;
  assign accept             = hz.ex_valid && hz.ex_is_long && !hz.ex_stall;
  assign hz.flush_before_wb = flush;
  assign hz.long_kill       = flush || reset;
  assign hz.long_count      = long_count;

  long_scoreboard #(
    .NREGS(NREGS), .REG_W(REG_W), .MAX_LONG(MAX_LONG), .CNT_W(CNT_W)
  ) u_long_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .accept       (accept),
    .accept_en_rd (hz.ex_en_rd),
    .accept_rd    (hz.ex_rd),
    .done         (hz.long_done),
    .done_rd      (hz.long_done_rd),
    .busy         (busy),
    .count        (long_count)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_W(5), .MAX_LONG(4)) hz ();

  hazard_scoreboard #(.NREGS(32), .REG_W(5), .MAX_LONG(4)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    hz.id_valid = 0; hz.id_en_rs1 = 0; hz.id_en_rs2 = 0; hz.id_en_rd = 0; hz.id_is_ecall = 0;
    hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_rd = 0;
    hz.ex_valid = 0; hz.ex_en_rd = 0; hz.ex_is_load = 0; hz.ex_is_long = 0; hz.ex_rd = 0;
    hz.mem_valid = 0; hz.mem_en_rd = 0; hz.mem_is_load = 0; hz.mem_is_store = 0; hz.mem_rd = 0;
    hz.wb_valid = 0; hz.wb_en_rd = 0; hz.wb_is_ecall = 0; hz.wb_rd = 0;
    hz.dcache_enable = 0; hz.dcache_valid = 0; hz.write_done = 0;
    hz.ecall_stall = 0; hz.long_done = 0; hz.long_done_rd = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_long(input logic [4:0] rd);
    hz.ex_valid = 1; hz.ex_is_long = 1; hz.ex_en_rd = 1; hz.ex_rd = rd;
  endtask

  task automatic done(input logic [4:0] rd);
    hz.long_done = 1; hz.long_done_rd = rd;
  endtask

  initial begin
    idle();
    reset = 1;
    #1;
    check("kill_in_reset", hz.long_kill, 1);
    step();
    check("reset_count", hz.long_count, 0);
    reset = 0;
    #1;
    check("idle_id_stall", hz.id_stall, 0);
    check("idle_ex_stall", hz.ex_stall, 0);
    check("idle_mem_stall", hz.mem_stall, 0);
    check("idle_wb_stall", hz.wb_stall, 0);
    check("idle_flush", hz.flush_before_wb, 0);
    check("idle_kill", hz.long_kill, 0);
    check("idle_fwd1", hz.fwd_rs1_sel, 0);
    check("idle_fwd2", hz.fwd_rs2_sel, 0);

    // EX -> ID forward and priority down the pipe
    hz.id_valid = 1; hz.id_en_rs1 = 1; hz.id_rs1 = 5;
    hz.ex_valid = 1; hz.ex_en_rd = 1; hz.ex_rd = 5;
    #1;
    check("ex_fwd", hz.fwd_rs1_sel, 1);
    check("ex_fwd_nostall", hz.id_stall, 0);
    hz.mem_valid = 1; hz.mem_en_rd = 1; hz.mem_rd = 5;
    #1;
    check("ex_over_mem", hz.fwd_rs1_sel, 1);
    hz.ex_valid = 0;
    #1;
    check("mem_fwd", hz.fwd_rs1_sel, 2);
    hz.mem_valid = 0; hz.wb_valid = 1; hz.wb_en_rd = 1; hz.wb_rd = 5;
    #1;
    check("wb_fwd", hz.fwd_rs1_sel, 3);

    // load-use then MEM forward
    step(); idle();
    hz.id_valid = 1; hz.id_en_rs2 = 1; hz.id_rs2 = 7;
    hz.ex_valid = 1; hz.ex_en_rd = 1; hz.ex_is_load = 1; hz.ex_rd = 7;
    #1;
    check("load_use_stall", hz.id_stall, 1);
    check("load_use_nofwd", hz.fwd_rs2_sel, 0);
    step();
    hz.ex_valid = 0; hz.ex_is_load = 0;
    hz.mem_valid = 1; hz.mem_en_rd = 1; hz.mem_is_load = 1; hz.mem_rd = 7;
    #1;
    check("load_mem_nostall", hz.id_stall, 0);
    check("load_mem_fwd", hz.fwd_rs2_sel, 2);

    // dcache miss and ecall-handler cascade
    hz.dcache_enable = 1;
    #1;
    check("miss_mem_stall", hz.mem_stall, 1);
    check("miss_ex_stall", hz.ex_stall, 1);
    check("miss_id_stall", hz.id_stall, 1);
    check("miss_wb_stall", hz.wb_stall, 0);
    hz.dcache_valid = 1;
    #1;
    check("hit_mem_stall", hz.mem_stall, 0);
    hz.ecall_stall = 1;
    #1;
    check("ecall_wb_stall", hz.wb_stall, 1);
    check("ecall_mem_stall", hz.mem_stall, 1);
    check("ecall_ex_stall", hz.ex_stall, 1);

    // long op to x9 with a consumer behind it
    step(); idle();
    ex_long(9);
    hz.id_valid = 1; hz.id_en_rs1 = 1; hz.id_rs1 = 9;
    #1;
    check("ex_long_use_stall", hz.id_stall, 1);
    check("ex_long_accept_ok", hz.ex_stall, 0);
    step();
    hz.ex_valid = 0; hz.ex_is_long = 0; hz.ex_en_rd = 0;
    #1;
    check("long_count_1", hz.long_count, 1);
    check("busy9_stall", hz.id_stall, 1);
    step();
    check("busy9_still", hz.id_stall, 1);
    done(9);
    #1;
    check("long_done_fwd", hz.fwd_rs1_sel, 4);
    check("long_done_nostall", hz.id_stall, 0);
    step();
    hz.long_done = 0;
    #1;
    check("after_done_count", hz.long_count, 0);
    check("after_done_nostall", hz.id_stall, 0);
    check("after_done_rf", hz.fwd_rs1_sel, 0);

    // fill the long unit
    idle();
    for (int i = 1; i <= 4; i++) begin
      ex_long(5'(i));
      step();
    end
    idle();
    #1;
    check("full_count", hz.long_count, 4);
    ex_long(10);
    hz.id_valid = 1;
    #1;
    check("full_ex_stall", hz.ex_stall, 1);
    check("full_id_stall", hz.id_stall, 1);
    step(); idle();
    check("full_held", hz.long_count, 4);
    done(1);
    step(); idle();
    check("drop_to_3", hz.long_count, 3);
    ex_long(11); done(2);
    #1;
    check("simul_accept_ok", hz.ex_stall, 0);
    step(); idle();
    check("simul_count", hz.long_count, 3);
    hz.id_valid = 1; hz.id_en_rd = 1; hz.id_rd = 3;
    #1;
    check("waw_stall", hz.id_stall, 1);
    idle();
    ex_long(3);
    #1;
    check("ex_busy_rd_block", hz.ex_stall, 1);

    // ecall drain (busy: x3, x4, x11)
    idle();
    hz.id_valid = 1; hz.id_is_ecall = 1;
    #1;
    check("ecall_drain_stall", hz.id_stall, 1);
    done(3);  step();
    done(4);  step();
    check("ecall_drain_wait", hz.id_stall, 1);
    done(11); step();
    hz.long_done = 0;
    #1;
    check("drained_count", hz.long_count, 0);
    check("drained_nostall", hz.id_stall, 0);

    // ecall reaches WB: flush kills a freshly accepted long op
    idle();
    hz.wb_valid = 1; hz.wb_is_ecall = 1;
    ex_long(12);
    #1;
    check("flush", hz.flush_before_wb, 1);
    check("flush_kill", hz.long_kill, 1);
    step(); idle();
    hz.id_valid = 1; hz.id_en_rs1 = 1; hz.id_rs1 = 12;
    #1;
    check("flush_count", hz.long_count, 0);
    check("flush_busy_clear", hz.id_stall, 0);
    check("flush_kill_off", hz.long_kill, 0);

    // reset mid-operation
    idle();
    ex_long(13);
    step(); idle();
    check("pre_reset_count", hz.long_count, 1);
    reset = 1;
    step();
    reset = 0;
    hz.id_valid = 1; hz.id_en_rs1 = 1; hz.id_rs1 = 13;
    #1;
    check("reset_count_clear", hz.long_count, 0);
    check("reset_busy_clear", hz.id_stall, 0);

    // x0 never forwards or stalls
    idle();
    hz.id_valid = 1; hz.id_en_rs1 = 1; hz.id_en_rs2 = 1;
    hz.ex_valid = 1; hz.ex_en_rd = 1; hz.ex_is_load = 1; hz.ex_rd = 0;
    hz.mem_valid = 1; hz.mem_en_rd = 1; hz.mem_rd = 0;
    #1;
    check("x0_no_stall", hz.id_stall, 0);
    check("x0_fwd1", hz.fwd_rs1_sel, 0);
    check("x0_fwd2", hz.fwd_rs2_sel, 0);
    idle();
    ex_long(0);
    step(); idle();
    hz.id_valid = 1; hz.id_en_rs1 = 1; hz.id_en_rd = 1;
    #1;
    check("x0_long_count", hz.long_count, 1);
    check("x0_long_nostall", hz.id_stall, 0);
    idle();
    done(0);
    step(); idle();
    check("x0_long_done", hz.long_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
